// File: rtl/exp_1x1_ker_read_cont_if.sv
// exp_1x1_ker_read_cont_if: kernel RAM read / MAC-array bus of the expand 1x1 read sequencer
// Ports (master = sequencer side):
//   exp_1x1_ram_rd_addr_o  kernel RAM read address
//   exp_1x1_ram_rd_en_o    kernel RAM read enable
//   ker_valid_o            RAM output word valid (rd_en delayed by the RAM latency)
//   ker_layer_last_o       last word of a layer, aligned with ker_valid_o
//   pass_done_o            1-cycle pulse with the last read of a pass
//   busy_o                 sequencer not idle
//   stall_i                downstream back-pressure, blocks new reads
interface exp_1x1_ker_read_cont_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] exp_1x1_ram_rd_addr_o;
    logic              exp_1x1_ram_rd_en_o;
    logic              ker_valid_o;
    logic              ker_layer_last_o;
    logic              pass_done_o;
    logic              busy_o;
    logic              stall_i;

    modport master (
        output exp_1x1_ram_rd_addr_o, exp_1x1_ram_rd_en_o, ker_valid_o,
               ker_layer_last_o, pass_done_o, busy_o,
        input  stall_i
    );

    modport slave (
        input  exp_1x1_ram_rd_addr_o, exp_1x1_ram_rd_en_o, ker_valid_o,
               ker_layer_last_o, pass_done_o, busy_o,
        output stall_i
    );
endinterface

// File: rtl/exp_1x1_ker_read_cont.sv
// exp_1x1_ker_read_cont: read-side sequencer for the expand 1x1 kernel RAM
// Walks the RAM layer by layer, waiting for each layer to be reported written, and repeats the
// whole depth walk once per output pass.
// Ports:
//   clk_i, rst_n_i                 clock, asynchronous active-low reset
//   start_i, exp_1x1_en_i          load config and (re)start; start ignored-to-idle when en is low
//   one_exp1_ker_addr_limit_i      words per layer minus 1
//   exp1_layer_limit_i             layers (depth) minus 1
//   exp1_pass_limit_i              passes minus 1
//   exp_1x1_layer_ready_no_i       number of fully written layers
//   bus                            RAM read / MAC-array side (see exp_1x1_ker_read_cont_if)
module exp_1x1_ker_read_cont #(
    parameter int ADDR_W  = 12,
    parameter int LAYER_W = 7,
    parameter int PASS_W  = 12,
    parameter int RD_LAT  = 1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic               exp_1x1_en_i,
    input  logic [LAYER_W-1:0] one_exp1_ker_addr_limit_i,
    input  logic [LAYER_W-1:0] exp1_layer_limit_i,
    input  logic [PASS_W-1:0]  exp1_pass_limit_i,
    input  logic [LAYER_W-1:0] exp_1x1_layer_ready_no_i,
    exp_1x1_ker_read_cont_if.master bus
);
    typedef enum logic [1:0] {IDLE, WAIT, READ} state_t;

    state_t             state;
    logic [LAYER_W-1:0] w_lim, d_lim, word_cnt, layer_cnt;
    logic [PASS_W-1:0]  p_lim, pass_cnt;
    logic [ADDR_W-1:0]  base;
    logic               rd_last;
    logic [RD_LAT-1:0]  v_pipe, l_pipe;
    logic               word_end, layer_end, pass_end, issue;

    assign word_end  = word_cnt == w_lim;
    assign layer_end = layer_cnt == d_lim;
    assign pass_end  = pass_cnt == p_lim;
    assign issue     = state == READ && !bus.stall_i;

    assign bus.ker_valid_o      = v_pipe[RD_LAT-1];
    assign bus.ker_layer_last_o = l_pipe[RD_LAT-1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state                     <= IDLE;
            w_lim                     <= '0;
            d_lim                     <= '0;
            p_lim                     <= '0;
            word_cnt                  <= '0;
            layer_cnt                 <= '0;
            pass_cnt                  <= '0;
            base                      <= '0;
            rd_last                   <= 1'b0;
            v_pipe                    <= '0;
            l_pipe                    <= '0;
            bus.exp_1x1_ram_rd_addr_o <= '0;
            bus.exp_1x1_ram_rd_en_o   <= 1'b0;
            bus.pass_done_o           <= 1'b0;
            bus.busy_o                <= 1'b0;
        end else begin
            // Output pipe keeps draining through stalls; the truncating cast shifts in rd_en.
            v_pipe                  <= RD_LAT'({v_pipe, bus.exp_1x1_ram_rd_en_o});
            l_pipe                  <= RD_LAT'({l_pipe, bus.exp_1x1_ram_rd_en_o && rd_last});
            bus.exp_1x1_ram_rd_en_o <= 1'b0;
            bus.pass_done_o         <= 1'b0;
            if (start_i) begin
                // A start from IDLE lets the previous pass's tail drain; any other start discards it.
                if (state != IDLE || !exp_1x1_en_i) begin
                    v_pipe <= '0;
                    l_pipe <= '0;
                end
                if (exp_1x1_en_i) begin
                    w_lim <= one_exp1_ker_addr_limit_i;
                    d_lim <= exp1_layer_limit_i;
                    p_lim <= exp1_pass_limit_i;
                end
                state                     <= exp_1x1_en_i ? WAIT : IDLE;
                bus.busy_o                <= exp_1x1_en_i;
                word_cnt                  <= '0;
                layer_cnt                 <= '0;
                pass_cnt                  <= '0;
                base                      <= '0;
                bus.exp_1x1_ram_rd_addr_o <= '0;
            end else if (state == WAIT) begin
                if (exp_1x1_layer_ready_no_i > layer_cnt)
                    state <= READ;
            end else if (issue) begin
                bus.exp_1x1_ram_rd_en_o   <= 1'b1;
                bus.exp_1x1_ram_rd_addr_o <= base + ADDR_W'(word_cnt);
                rd_last                   <= word_end;
                bus.pass_done_o           <= word_end && layer_end;
                if (!word_end) begin
                    word_cnt <= word_cnt + 1'b1;
                end else begin
                    word_cnt <= '0;
                    if (!layer_end) begin
                        base      <= base + ADDR_W'(w_lim) + 1'b1;
                        layer_cnt <= layer_cnt + 1'b1;
                        state     <= WAIT;
                    end else begin
                        base      <= '0;
                        layer_cnt <= '0;
                        if (pass_end) begin
                            state      <= IDLE;
                            bus.busy_o <= 1'b0;
                        end else begin
                            pass_cnt <= pass_cnt + 1'b1;
                            state    <= WAIT;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_exp_1x1_ker_read_cont.sv
// tb_exp_1x1_ker_read_cont: table-driven, directed and randomized checks of the kernel read sequencer
module tb_exp_1x1_ker_read_cont;
    localparam int ADDR_W  = 12;
    localparam int LAYER_W = 7;
    localparam int PASS_W  = 12;
    localparam int RD_LAT  = 1;

    logic               clk_i = 1'b0;
    logic               rst_n_i = 1'b0;
    logic               start_i = 1'b0;
    logic               exp_1x1_en_i = 1'b0;
    logic [LAYER_W-1:0] w_lim_i = '0, d_lim_i = '0, ready = '0;
    logic [PASS_W-1:0]  p_lim_i = '0;

    exp_1x1_ker_read_cont_if #(.ADDR_W(ADDR_W)) bus ();

    exp_1x1_ker_read_cont #(
        .ADDR_W(ADDR_W), .LAYER_W(LAYER_W), .PASS_W(PASS_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk_i                     (clk_i),
        .rst_n_i                   (rst_n_i),
        .start_i                   (start_i),
        .exp_1x1_en_i              (exp_1x1_en_i),
        .one_exp1_ker_addr_limit_i (w_lim_i),
        .exp1_layer_limit_i        (d_lim_i),
        .exp1_pass_limit_i         (p_lim_i),
        .exp_1x1_layer_ready_no_i  (ready),
        .bus                       (bus.master)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {int addr; bit last; bit pd; int layer;} word_t;
    typedef struct {int due; bit last;} vexp_t;
    typedef struct {int w; int d; int p; int words; int passes; int last;} vec_t;

    word_t exp_q[$];
    vexp_t vq[$];
    vec_t  tbl[5];
    int checks = 0, errors = 0, cyc = 0;
    int nwords, npass, last_addr, last_rd_cyc, max_gap, cur_d;
    int stall_pct = 0, ready_step = 0;
    bit auto_stall = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected issue order straight from the walk: pass -> layer -> word, addr = layer*W + word.
    function automatic void build(input int w, input int d, input int p);
        exp_q.delete();
        for (int pp = 0; pp < p; pp++)
            for (int l = 0; l < d; l++)
                for (int k = 0; k < w; k++) begin
                    word_t e;
                    e.addr  = (l * w + k) % (1 << ADDR_W);
                    e.last  = (k == w - 1);
                    e.pd    = (k == w - 1) && (l == d - 1);
                    e.layer = l;
                    exp_q.push_back(e);
                end
    endfunction

    task automatic monitor();
        if (bus.exp_1x1_ram_rd_en_o) begin
            chk("rd_during_stall", bus.stall_i, 0);
            if (exp_q.size() == 0) chk("extra_rd", 1, 0);
            else begin
                word_t e = exp_q.pop_front();
                vexp_t v;
                chk("rd_addr", bus.exp_1x1_ram_rd_addr_o, e.addr);
                chk("pass_done", bus.pass_done_o, e.pd);
                chk("ready_gate", ready > e.layer, 1);
                v.due  = cyc + RD_LAT;
                v.last = e.last;
                vq.push_back(v);
                if (e.pd) npass++;
            end
            if (nwords > 0 && cyc - last_rd_cyc > max_gap) max_gap = cyc - last_rd_cyc;
            last_rd_cyc = cyc;
            last_addr   = int'(bus.exp_1x1_ram_rd_addr_o);
            nwords++;
        end else if (bus.pass_done_o) chk("pd_without_rd", 1, 0);
        if (bus.ker_valid_o) begin
            if (vq.size() == 0) chk("extra_valid", 1, 0);
            else begin
                vexp_t v = vq.pop_front();
                chk("valid_time", cyc, v.due);
                chk("layer_last", bus.ker_layer_last_o, v.last);
            end
        end else begin
            if (bus.ker_layer_last_o) chk("last_without_valid", 1, 0);
            if (vq.size() > 0 && vq[0].due == cyc) begin
                chk("missing_valid", 0, 1);
                void'(vq.pop_front());
            end
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        cyc++;
        monitor();
        if (auto_stall) bus.stall_i = ($urandom_range(99) < stall_pct);
        if (ready_step > 0 && int'(ready) < cur_d && $urandom_range(ready_step - 1) == 0) ready = ready + 1'b1;
    endtask

    task automatic do_start(input int w, input int d, input int p, input bit e);
        w_lim_i      = LAYER_W'(w - 1);
        d_lim_i      = LAYER_W'(d - 1);
        p_lim_i      = PASS_W'(p - 1);
        exp_1x1_en_i = e;
        start_i      = 1'b1;
        vq.delete();
        if (e) build(w, d, p);
        else exp_q.delete();
        nwords  = 0;
        npass   = 0;
        max_gap = 0;
        cur_d   = d;
        step();
        start_i = 1'b0;
        // Config must be latched: scramble it after the start.
        w_lim_i = LAYER_W'($urandom);
        d_lim_i = LAYER_W'($urandom);
        p_lim_i = PASS_W'($urandom);
        chk("busy_after_start", bus.busy_o, e);
        chk("valid_after_start", bus.ker_valid_o, 0);
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while ((bus.busy_o || exp_q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) chk("timeout", 1, 0);
        repeat (RD_LAT + 2) step();
        chk("pipe_drained", vq.size(), 0);
        chk("busy_end", bus.busy_o, 0);
    endtask

    initial begin
        bus.stall_i = 1'b0;
        tbl[0] = '{4, 3, 1, 12, 1, 11};
        tbl[1] = '{2, 2, 3, 12, 3, 3};
        tbl[2] = '{1, 1, 1, 1, 1, 0};
        tbl[3] = '{1, 4, 2, 8, 2, 3};
        tbl[4] = '{8, 2, 1, 16, 1, 15};

        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_rd_en", bus.exp_1x1_ram_rd_en_o, 0);
        chk("rst_addr", bus.exp_1x1_ram_rd_addr_o, 0);
        chk("rst_valid", bus.ker_valid_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_pass_done", bus.pass_done_o, 0);
        #2 rst_n_i = 1'b1;

        // Table: all layers ready, no stall.
        for (int i = 0; i < 5; i++) begin
            ready = LAYER_W'(tbl[i].d);
            do_start(tbl[i].w, tbl[i].d, tbl[i].p, 1'b1);
            run_idle(500);
            chk("tbl_words", nwords, tbl[i].words);
            chk("tbl_passes", npass, tbl[i].passes);
            chk("tbl_last_addr", last_addr, tbl[i].last);
            chk("tbl_gap_ok", max_gap <= 2, 1);
        end

        // Layers become ready one at a time.
        ready = '0;
        do_start(4, 3, 1, 1'b1);
        repeat (15) step();
        chk("no_rd_before_ready", nwords, 0);
        for (int k = 1; k <= 3; k++) begin
            ready = LAYER_W'(k);
            repeat (20) step();
            chk("ready_step_words", nwords, 4 * k);
        end
        run_idle(50);

        // Stall mid-layer at address 6.
        begin
            int n = 0;
            ready = 7'd3;
            do_start(4, 3, 1, 1'b1);
            while (!(bus.exp_1x1_ram_rd_en_o && bus.exp_1x1_ram_rd_addr_o == 6) && n < 50) begin
                step();
                n++;
            end
            chk("reach_addr6", n < 50, 1);
            bus.stall_i = 1'b1;
            repeat (5) begin
                step();
                chk("stall_addr_hold", bus.exp_1x1_ram_rd_addr_o, 6);
                chk("stall_no_rd", bus.exp_1x1_ram_rd_en_o, 0);
            end
            bus.stall_i = 1'b0;
            run_idle(100);
            chk("stall_words", nwords, 12);
        end

        // Restart during the second pass of four.
        begin
            int n = 0;
            ready = 7'd2;
            do_start(2, 2, 4, 1'b1);
            while (npass < 1 && n < 100) begin
                step();
                n++;
            end
            step();
            step();
            chk("restart_midrun_rd", bus.exp_1x1_ram_rd_en_o, 1);
            do_start(2, 2, 4, 1'b1);
            run_idle(200);
            chk("restart_words", nwords, 16);
            chk("restart_passes", npass, 4);
        end

        // Start with enable low while busy forces idle.
        ready = 7'd2;
        do_start(2, 2, 1, 1'b1);
        repeat (3) step();
        do_start(2, 2, 1, 1'b0);
        chk("dis_rd_en", bus.exp_1x1_ram_rd_en_o, 0);
        chk("dis_addr", bus.exp_1x1_ram_rd_addr_o, 0);
        repeat (5) step();
        chk("dis_words", nwords, 0);

        // Asynchronous reset mid-read, then a disabled start.
        ready = 7'd3;
        do_start(4, 3, 1, 1'b1);
        repeat (6) step();
        @(posedge clk_i);
        #3 rst_n_i = 1'b0;
        #1;
        chk("arst_rd_en", bus.exp_1x1_ram_rd_en_o, 0);
        chk("arst_addr", bus.exp_1x1_ram_rd_addr_o, 0);
        chk("arst_valid", bus.ker_valid_o, 0);
        chk("arst_last", bus.ker_layer_last_o, 0);
        chk("arst_pass_done", bus.pass_done_o, 0);
        chk("arst_busy", bus.busy_o, 0);
        exp_q.delete();
        vq.delete();
        #2 rst_n_i = 1'b1;
        do_start(4, 3, 1, 1'b0);
        repeat (5) step();
        chk("dis_after_rst_busy", bus.busy_o, 0);
        chk("dis_after_rst_words", nwords, 0);

        // Randomized configs, ready ramps and stalls.
        auto_stall = 1;
        stall_pct  = 25;
        ready_step = 4;
        for (int i = 0; i < 15; i++) begin
            int w = $urandom_range(1, 8), d = $urandom_range(1, 4), p = $urandom_range(1, 3);
            ready = LAYER_W'($urandom_range(0, d));
            do_start(w, d, p, 1'b1);
            run_idle(3000);
            chk("rand_words", nwords, w * d * p);
            chk("rand_passes", npass, p);
        end
        auto_stall  = 0;
        bus.stall_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
